// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID fetch queue.
//   PC_W / INSTR_W   : field widths of a fetch entry
//   EXC_INT          : exception code meaning "no exception" (Int)
//   RESET_PC_DEF     : default bubble PC after reset
//   HANDLER_PC_DEF   : default bubble PC after an exception request
package if_id_queue_pkg;

    localparam int unsigned PC_W           = 32;
    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned EXC_INT        = 0;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    // Width of one stored entry {pc, instr, exc, bd}
    function automatic int unsigned entry_w(input int unsigned exc_w);
        return PC_W + INSTR_W + exc_w + 1;
    endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: DEPTH x W, one write port,
// one asynchronous read port. Contents are not reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module if_id_queue_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 70,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID fetch queue: circular buffer between fetch and decode with
// flush on exception request (redirect to HANDLER_PC) or ERET (to epc).
// When empty the head presents a bubble {bubble_pc, 0, Int, 0}.
//   clk, reset                      : clock, async active-high reset
//   in_valid/in_ready/in_*          : fetch-side enqueue handshake + entry
//   out_valid/out_ready/out_*       : decode-side head entry + consume
//   req, eret, epc                  : flush controls and ERET target
//   count                           : current occupancy
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter int unsigned EXC_W      = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic [EXC_W-1:0]           in_exc,
    input  logic                       in_bd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [EXC_W-1:0]           out_exc,
    output logic                       out_bd,
    input  logic                       req,
    input  logic                       eret,
    input  logic [31:0]                epc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = entry_w(EXC_W);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("if_id_queue: DEPTH must be a power of two >= 2");
    end

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [31:0]      r_bubble_pc;

    logic             w_flush;
    logic             w_enq;
    logic             w_deq;
    logic [EW-1:0]    w_wdata;
    logic [EW-1:0]    w_rdata;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_instr;
    logic [EXC_W-1:0] w_head_exc;
    logic             w_head_bd;

    // in_ready comes from occupancy only, so a full queue never passes through
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_flush   = req | eret;
    assign w_enq     = in_valid & in_ready & ~w_flush;
    assign w_deq     = out_valid & out_ready & ~w_flush;
    assign w_wdata   = {in_pc, in_instr, in_exc, in_bd};

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign {w_head_pc, w_head_instr, w_head_exc, w_head_bd} = w_rdata;

    // Pointers, occupancy and bubble PC; req outranks eret
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_bubble_pc <= RESET_PC;
        end else if (req) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_bubble_pc <= HANDLER_PC;
        end else if (eret) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_bubble_pc <= epc;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Head entry or bubble; stale storage is masked while empty
    always_comb begin
        out_pc    = r_bubble_pc;
        out_instr = '0;
        out_exc   = EXC_W'(EXC_INT);
        out_bd    = 1'b0;
        if (out_valid) begin
            out_pc    = w_head_pc;
            out_instr = w_head_instr;
            out_exc   = w_head_exc;
            out_bd    = w_head_bd;
        end
    end

    assign count = r_count;

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered fetch entries; SHALL be a power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h00003000, bubble PC presented after reset.
REQ-003 Parameter HANDLER_PC, default 32'h00004180, bubble PC presented after an exception request.
REQ-004 Parameter EXC_W, default 5, width of the exception-code field.
REQ-005 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  queue accepts the entry.
- in_pc  in  32  fetch PC.
- in_instr  in  32  fetched instruction.
- in_exc  in  EXC_W  fetch exception code.
- in_bd  in  1  branch-delay-slot flag.
- out_valid  out  1  head entry valid to decode.
- out_ready  in  1  decode consumes the head.
- out_pc  out  32  head PC, or bubble PC when empty.
- out_instr  out  32  head instruction, or 0 when empty.
- out_exc  out  EXC_W  head exception code, or `Int when empty.
- out_bd  out  1  head BD flag, or 0 when empty.
- req  in  1  exception or interrupt flush.
- eret  in  1  ERET redirect flush.
- epc  in  32  ERET target.
- count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-006 Each entry SHALL hold {pc, instr, exc, bd}, with circular read/write pointers wrapping modulo DEPTH.
REQ-007 Enqueue SHALL occur on a rising edge when in_valid && in_ready && !req && !eret.
REQ-008 in_ready SHALL be 1 exactly when count < DEPTH; it SHALL not depend combinationally on out_ready (no pass-through when full).
REQ-009 Dequeue SHALL occur on a rising edge when out_valid && out_ready && !req && !eret.
REQ-010 A simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-011 out_valid SHALL equal (count != 0), and the out_* fields SHALL be driven from the head entry with no added latency; an entry written at edge N SHALL be visible at the head after edge N when the queue was empty.
REQ-012 When empty, out_* SHALL present the bubble: out_pc = bubble_pc, out_instr = 0, out_exc = `Int, out_bd = 0.
REQ-013 On an edge with req = 1, the queue SHALL empty (count = 0, pointers equal), discarding any same-cycle enqueue or dequeue, and bubble_pc SHALL become HANDLER_PC.
REQ-014 On an edge with eret = 1 and req = 0, the queue SHALL empty in the same way, and bubble_pc SHALL become epc.
REQ-015 req SHALL take priority over eret when both are 1.
REQ-016 Outside of flushes, bubble_pc SHALL hold its value.
REQ-017 Enqueue attempted while full SHALL be ignored; dequeue attempted while empty SHALL be ignored; count SHALL never exceed DEPTH or underflow.

Reset
REQ-018 While reset = 1, asynchronously: count = 0, both pointers = 0, bubble_pc = RESET_PC; outputs SHALL therefore be out_valid = 0, out_pc = RESET_PC, out_instr = 0, out_exc = `Int, out_bd = 0, in_ready = 1.
REQ-019 Entry storage SHALL not require reset; stale contents SHALL never be visible while count = 0.
REQ-020 Deassertion of reset mid-stream SHALL resume from the empty state, and no pre-reset entry SHALL reappear.

Structure
REQ-021 `Int, RESET_PC and HANDLER_PC defaults SHALL live in the shared constants include, with no literal values duplicated in the module body.
REQ-022 Entry storage SHALL be one sub-module, if_id_queue_mem (DEPTH x (64+EXC_W+1), 1 write port, 1 async read port); pointer, count and bubble logic SHALL stay in if_id_queue.

Verification
REQ-023 Reset: assert reset mid-cycle -> immediately out_valid = 0, out_pc = 32'h00003000, count = 0, in_ready = 1.
REQ-024 Fill: 4 enqueues (pc 0x3000..0x300C) with out_ready = 0 -> count = 4, in_ready = 0; 5th offer is dropped; then drain -> pcs appear in order 0x3000..0x300C.
REQ-025 Steady streaming: in_valid = out_ready = 1 for 10 cycles -> count stays 1 and every pc is delivered exactly once, in order, across the pointer wrap.
REQ-026 Exception flush: count = 3, pulse req with in_valid = 1 -> next cycle count = 0, out_pc = 32'h00004180, out_instr = 0, in_pc is not stored.
REQ-027 ERET: epc = 32'h00003040, pulse eret -> empty, out_pc = 32'h00003040; req and eret together -> out_pc = 32'h00004180.
REQ-028 Exception fields: enqueue in_exc = 5'd10 with in_bd = 1 -> the head shows exc 10 and bd 1 until dequeued, then `Int and 0.
